spk_pdm_modulator: RTL and testbench

//  2nd-order sigma-delta modulator: converts signed PCM samples to a 1-bit PDM stream for the speaker.

---
 rtl/spk_pdm_modulator.sv | 133 +++++++++++++
 tb/tb_spk_pdm_modulator.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spk_pdm_modulator.sv
// Second-order sigma-delta modulator: signed PCM in via valid/ready, 1-bit PDM out.
// Steps once per registered pdm_clk rising edge while running; one PCM sample per OSR bits.
module spk_pdm_modulator #(
    parameter int DATA_W = 16,
    parameter int OSR    = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              pdm_clk,
    input  logic              locked,
    input  logic [DATA_W-1:0] pcm_data,
    input  logic              pcm_valid,
    output logic              pcm_ready,
    output logic              pdm_out,
    output logic              underrun,
    input  logic              clr_underrun
);

    localparam int A1W = DATA_W + 2;
    localparam int A2W = DATA_W + 4;
    localparam int SW  = DATA_W + 6;
    localparam int CW  = $clog2(OSR);

    localparam logic signed [SW-1:0] FB_MAG = SW'(2 ** (DATA_W - 1));
    localparam logic signed [SW-1:0] A1_MAX = SW'((2 ** (A1W - 1)) - 1);
    localparam logic signed [SW-1:0] A1_MIN = SW'(-(2 ** (A1W - 1)));
    localparam logic signed [SW-1:0] A2_MAX = SW'((2 ** (A2W - 1)) - 1);
    localparam logic signed [SW-1:0] A2_MIN = SW'(-(2 ** (A2W - 1)));

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                   state;
    logic                     pdm_clk_q;
    logic                     hold_valid;
    logic signed [DATA_W-1:0] hold;
    logic signed [DATA_W-1:0] cur;
    logic signed [A1W-1:0]    acc1;
    logic signed [A2W-1:0]    acc2;
    logic [CW-1:0]            osr_cnt;

    logic                     run_ok;
    logic                     step;
    logic                     boundary;
    logic                     accept;
    logic                     load;
    logic                     starve;
    logic signed [SW-1:0]     fb;
    logic signed [SW-1:0]     x;
    logic signed [SW-1:0]     sum1;
    logic signed [SW-1:0]     sum2;
    logic signed [A1W-1:0]    acc1_new;
    logic signed [A2W-1:0]    acc2_new;

    assign pcm_ready = ~hold_valid;

    // A step on the edge that leaves RUN is suppressed so the held sample is not consumed.
    always_comb begin
        run_ok   = enable & locked;
        step     = pdm_clk & ~pdm_clk_q & (state == RUN) & run_ok;
        boundary = (osr_cnt == CW'(OSR - 1));
        accept   = pcm_valid & ~hold_valid;
        load     = step & boundary & hold_valid;
        starve   = step & boundary & ~hold_valid;

        fb = pdm_out ? FB_MAG : -FB_MAG;
        x  = SW'(cur) >>> 1;

        sum1 = SW'(acc1) + x - fb;
        if (sum1 > A1_MAX)      acc1_new = A1W'(A1_MAX);
        else if (sum1 < A1_MIN) acc1_new = A1W'(A1_MIN);
        else                    acc1_new = A1W'(sum1);

        sum2 = SW'(acc2) + SW'(acc1_new) - fb;
        if (sum2 > A2_MAX)      acc2_new = A2W'(A2_MAX);
        else if (sum2 < A2_MIN) acc2_new = A2W'(A2_MIN);
        else                    acc2_new = A2W'(sum2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pdm_clk_q  <= 1'b0;
            hold_valid <= 1'b0;
            hold       <= '0;
            cur        <= '0;
            acc1       <= '0;
            acc2       <= '0;
            osr_cnt    <= '0;
            pdm_out    <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            pdm_clk_q <= pdm_clk;

            if (accept) begin
                hold       <= pcm_data;
                hold_valid <= 1'b1;
            end else if (load) begin
                hold_valid <= 1'b0;
            end

            if (starve)            underrun <= 1'b1;
            else if (clr_underrun) underrun <= 1'b0;

            case (state)
                IDLE: begin
                    if (run_ok) state <= RUN;
                end
                RUN: begin
                    if (!run_ok) begin
                        state   <= IDLE;
                        acc1    <= '0;
                        acc2    <= '0;
                        cur     <= '0;
                        osr_cnt <= '0;
                        pdm_out <= 1'b0;
                    end else if (step) begin
                        acc1    <= acc1_new;
                        acc2    <= acc2_new;
                        pdm_out <= ~acc2_new[A2W-1];
                        osr_cnt <= boundary ? '0 : osr_cnt + CW'(1);
                        if (load) cur <= hold;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spk_pdm_modulator.sv
// Directed bench for spk_pdm_modulator (OSR=8): reset, bit patterns, densities, underrun, lock loss.
module tb_spk_pdm_modulator;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        pdm_clk;
    logic        locked;
    logic [15:0] pcm_data;
    logic        pcm_valid;
    logic        pcm_ready;
    logic        pdm_out;
    logic        underrun;
    logic        clr_underrun;

    int vectors;
    int miscompares;

    spk_pdm_modulator #(.DATA_W(16), .OSR(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .pdm_clk      (pdm_clk),
        .locked       (locked),
        .pcm_data     (pcm_data),
        .pcm_valid    (pcm_valid),
        .pcm_ready    (pcm_ready),
        .pdm_out      (pdm_out),
        .underrun     (underrun),
        .clr_underrun (clr_underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PDM bit clock at half the system clock rate, changing away from the sampling edge.
    initial pdm_clk = 1'b0;
    always @(negedge clk) pdm_clk = ~pdm_clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset(input logic en, input logic lk, input logic v, input logic [15:0] d);
        rst_n        = 1'b0;
        enable       = en;
        locked       = lk;
        pcm_valid    = v;
        pcm_data     = d;
        clr_underrun = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Advance to the next clk edge on which a modulator step occurs and return the new bit.
    task automatic step_bit(output logic b);
        logic pc;
        int   k;
        pc = 1'b0;
        k  = 0;
        while (!pc && k < 4) begin
            @(posedge clk);
            pc = pdm_clk;
            #1;
            k++;
        end
        if (!pc) begin
            vectors++;
            miscompares++;
            $display("FAIL step_timeout: got no pdm_clk rise, required one within 4 clk");
        end
        b = pdm_out;
    endtask

    task automatic measure(input int n, output int ones, output int xs);
        logic b;
        ones = 0;
        xs   = 0;
        for (int i = 0; i < n; i++) begin
            step_bit(b);
            if ($isunknown(b)) xs++;
            else if (b) ones++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            enable       = 1'($urandom_range(0, 1));
            locked       = 1'($urandom_range(0, 1));
            pcm_valid    = 1'($urandom_range(0, 1));
            clr_underrun = 1'($urandom_range(0, 1));
            pcm_data     = 16'($urandom);
            @(posedge clk);
            #1;
            vectors++;
            if (pdm_out !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_pdm_out: got %b required 0", pdm_out);
            end
            vectors++;
            if (pcm_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_pcm_ready: got %b required 1", pcm_ready);
            end
            vectors++;
            if (underrun !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_underrun: got %b required 0", underrun);
            end
        end
    endtask

    task automatic test_zero;
        bit   exp_z [8];
        logic b;
        int   ones;
        int   xs;
        exp_z = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset(1'b1, 1'b1, 1'b1, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            step_bit(b);
            vectors++;
            if (b !== exp_z[i]) begin
                miscompares++;
                $display("FAIL zero_bit%0d: got %b required %b", i, b, exp_z[i]);
            end
        end
        measure(1024, ones, xs);
        vectors++;
        if (ones < 508 || ones > 516 || xs != 0) begin
            miscompares++;
            $display("FAIL zero_density: got %0d ones (%0d X) required 508..516", ones, xs);
        end
        vectors++;
        if (underrun !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_underrun: got %b required 0", underrun);
        end
    endtask

    task automatic test_dc(input logic [15:0] d, input int n, input int lo, input int hi);
        int ones;
        int xs;
        do_reset(1'b1, 1'b1, 1'b1, d);
        measure(64, ones, xs);
        measure(n, ones, xs);
        vectors++;
        if (ones < lo || ones > hi) begin
            miscompares++;
            $display("FAIL dc_density_%h: got %0d ones of %0d required %0d..%0d", d, ones, n, lo, hi);
        end
        vectors++;
        if (xs != 0) begin
            miscompares++;
            $display("FAIL dc_no_x_%h: got %0d unknown bits required 0", d, xs);
        end
        vectors++;
        if (underrun !== 1'b0) begin
            miscompares++;
            $display("FAIL dc_underrun_%h: got %b required 0", d, underrun);
        end
    endtask

    task automatic test_underrun;
        logic b;
        do_reset(1'b0, 1'b1, 1'b1, 16'h1000);
        vectors++;
        if (pcm_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL prefill_ready: got %b required 0", pcm_ready);
        end
        pcm_valid = 1'b0;
        enable    = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 1; n <= 32; n++) begin
            step_bit(b);
            if (n == 8 || n == 16) begin
                vectors++;
                if (underrun !== 1'b0) begin
                    miscompares++;
                    $display("FAIL underrun_step%0d: got %b required 0", n, underrun);
                end
                vectors++;
                if (pcm_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL ready_after_load_step%0d: got %b required 1", n, pcm_ready);
                end
            end
            if (n == 8) begin
                pcm_valid = 1'b1;
                pcm_data  = 16'h2000;
            end
            if (n == 9) begin
                vectors++;
                if (pcm_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL second_accept: got ready %b required 0", pcm_ready);
                end
                pcm_valid = 1'b0;
            end
            if (n == 24) begin
                vectors++;
                if (underrun !== 1'b1) begin
                    miscompares++;
                    $display("FAIL underrun_set: got %b required 1", underrun);
                end
                clr_underrun = 1'b1;
            end
            if (n == 25 || n == 31) begin
                vectors++;
                if (underrun !== 1'b0) begin
                    miscompares++;
                    $display("FAIL underrun_clear_step%0d: got %b required 0", n, underrun);
                end
            end
            if (n == 32) begin
                vectors++;
                if (underrun !== 1'b1) begin
                    miscompares++;
                    $display("FAIL underrun_set_wins: got %b required 1", underrun);
                end
                clr_underrun = 1'b0;
            end
        end
    endtask

    task automatic test_async_reset;
        int k;
        pcm_valid = 1'b1;
        pcm_data  = 16'h4000;
        @(posedge clk);
        #1;
        pcm_valid = 1'b0;
        vectors++;
        if (pcm_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL pre_rst_ready: got %b required 0", pcm_ready);
        end
        vectors++;
        if (underrun !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_rst_underrun: got %b required 1", underrun);
        end
        k = 0;
        while (pdm_out !== 1'b1 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        vectors++;
        if (pdm_out !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_rst_pdm_high: got %b required 1 within 20 clk", pdm_out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (pdm_out !== 1'b0 || pcm_ready !== 1'b1 || underrun !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got pdm=%b ready=%b underrun=%b required 0 1 0",
                     pdm_out, pcm_ready, underrun);
        end
    endtask

    task automatic test_locked_drop;
        bit   exp_z [8];
        logic b;
        int   k;
        exp_z = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset(1'b1, 1'b1, 1'b1, 16'h4000);
        for (int n = 1; n <= 33; n++) step_bit(b);
        vectors++;
        if (pcm_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_hold_full: got ready %b required 0", pcm_ready);
        end
        pcm_valid = 1'b0;
        k = 0;
        while (b !== 1'b1 && k < 5) begin
            step_bit(b);
            k++;
        end
        vectors++;
        if (b !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_pdm_high: got %b required 1 before lock loss", b);
        end
        locked = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (pdm_out !== 1'b0 || pcm_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL unlocked_clk%0d: got pdm=%b ready=%b required 0 0", i, pdm_out, pcm_ready);
            end
        end
        locked = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            step_bit(b);
            vectors++;
            if (b !== exp_z[i]) begin
                miscompares++;
                $display("FAIL resume_bit%0d: got %b required %b", i, b, exp_z[i]);
            end
        end
        vectors++;
        if (pcm_ready !== 1'b1 || underrun !== 1'b0) begin
            miscompares++;
            $display("FAIL resume_load: got ready=%b underrun=%b required 1 0", pcm_ready, underrun);
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst_n        = 1'b0;
        enable       = 1'b0;
        locked       = 1'b0;
        pcm_data     = '0;
        pcm_valid    = 1'b0;
        clr_underrun = 1'b0;

        test_reset;
        test_zero;
        test_dc(16'h4000, 4096, 2519, 2601);
        test_dc(16'hC000, 4096, 1495, 1577);
        test_dc(16'h7FFF, 8192, 6062, 6226);
        test_underrun;
        test_async_reset;
        test_locked_drop;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
